rc_lowpass_filter: RTL

Single-pole RC low-pass stage that sits directly downstream of the inverter square-wave oscillator. It consumes the oscillator's 16-bit sample on each audio clock enable and produces the capacitor-voltage waveform y[n] = y[n-1] + α·(x[n] − y[n-1]). It uses a 16-cycle serial shift-add multiplier, so no DSP block is needed. The coefficient α is derived at elaboration from R, C and SAMPLE_RATE.

---
 rtl/discrete_pkg.sv | 36 +++
 rtl/serial_mult_s17u16.sv | 56 +++++
 rtl/rc_lowpass_filter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/discrete_pkg.sv
// Shared constants, coefficient helper and FSM state type for the discrete-time
// analog-model stages (RC filters, integrators).
//   ONE_16 / ROUND_16 / MICRO_16 : Q16 fixed-point constants
//   rc_alpha_q16()               : single-pole RC coefficient in Q0.16, clamped to 1..65535
//   rc_state_e                   : sequencing states of a serial-multiply filter stage
package discrete_pkg;

    localparam longint unsigned ONE_16   = 64'd65536;
    localparam longint unsigned ROUND_16 = 64'd32768;
    localparam longint unsigned MICRO_16 = 64'd65536000000;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StAcc
    } rc_state_e;

    // alpha = dt / (RC + dt) with dt = 1/sample_rate and C in uF scaled by 2^16.
    function automatic logic [15:0] rc_alpha_q16(
        input longint unsigned sample_rate,
        input longint unsigned r,
        input longint unsigned c_16_shifted
    );
        longint unsigned den;
        longint unsigned q;
        den = sample_rate * r * c_16_shifted + MICRO_16;
        q   = (ONE_16 * MICRO_16) / den;
        if (q < 64'd1) begin
            q = 64'd1;
        end else if (q > 64'd65535) begin
            q = 64'd65535;
        end
        return q[15:0];
    endfunction

endpackage

// File: rtl/serial_mult_s17u16.sv
// Serial shift-add multiplier: signed 17-bit a times unsigned 16-bit b, one
// multiplier bit per clock, LSB first, 16 cycles.
//   clk, reset_n : clock, asynchronous active-low reset (discards any partial product)
//   start        : load operands and clear the accumulator
//   a, b         : multiplicand (signed), multiplier (unsigned)
//   done         : high during the cycle whose closing edge performs the final step;
//                  p holds the complete product after that edge
//   p            : signed 33-bit product accumulator
module serial_mult_s17u16 (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic signed [16:0] a,
    input  logic        [15:0] b,
    output logic               done,
    output logic signed [32:0] p
);

    logic signed [32:0] acc_q;
    logic signed [32:0] a_q;
    logic        [15:0] b_q;
    logic        [3:0]  cnt_q;
    logic               run_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            acc_q <= '0;
            a_q   <= {{16{a[16]}}, a};
            b_q   <= b;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (b_q[0]) begin
                acc_q <= acc_q + a_q;
            end
            a_q   <= a_q <<< 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                run_q <= 1'b0;
            end
        end
    end

    always_comb begin
        done = run_q && (cnt_q == 4'd15);
        p    = acc_q;
    end

endmodule

// File: rtl/rc_lowpass_filter.sv
// Single-pole RC low-pass stage: y[n] = y[n-1] + alpha * (x[n] - y[n-1]).
// One sample takes 18 clocks (register, 16 serial multiply steps, accumulate).
//   clk, reset_n  : clock, asynchronous active-low reset
//   audio_clk_en  : one-cycle sample strobe; dropped (overrun) while busy
//   in            : unsigned input sample
//   out           : unsigned filtered sample, held between updates
//   out_valid     : one-cycle pulse after out updates
//   busy          : a sample is being processed
//   overrun       : one-cycle pulse when a strobe was dropped
module rc_lowpass_filter
    import discrete_pkg::*;
#(
    parameter int unsigned CLOCK_RATE     = 50000000,
    parameter int unsigned SAMPLE_RATE    = 48000,
    parameter int unsigned R              = 4300,
    parameter int unsigned C_16_SHIFTED   = 655360,
    parameter int unsigned ALPHA_OVERRIDE = 0,
    parameter int unsigned WIDTH          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             audio_clk_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam logic [15:0] ALPHA = (ALPHA_OVERRIDE != 0) ? ALPHA_OVERRIDE[15:0] :
        rc_alpha_q16(64'(SAMPLE_RATE), 64'(R), 64'(C_16_SHIFTED));
    localparam logic signed [33:0] ROUND = 34'(ROUND_16);

    rc_state_e state_q, state_d;

    logic               start;
    logic               acc_en;
    logic               mul_done;
    logic signed [16:0] diff;
    logic signed [32:0] prod;
    logic signed [33:0] rounded;
    logic signed [34:0] y_wide;
    logic        [15:0] y_sat;
    logic        [15:0] y_q;
    logic               out_valid_q;
    logic               overrun_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (audio_clk_en) state_d = StMul;
            StMul:   if (mul_done) state_d = StAcc;
            StAcc:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        start  = (state_q == StIdle) && audio_clk_en;
        busy   = (state_q != StIdle);
        acc_en = (state_q == StAcc);
    end

    // d is captured inside the multiplier's operand register at the accepting edge.
    always_comb begin
        diff = $signed({1'b0, in}) - $signed({1'b0, y_q});
    end

    serial_mult_s17u16 u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (diff),
        .b       (ALPHA),
        .done    (mul_done),
        .p       (prod)
    );

    // Round half up, arithmetic shift, then saturate to the unsigned sample range.
    always_comb begin
        rounded = {prod[32], prod} + ROUND;
        y_wide  = $signed({19'b0, y_q}) + ($signed({rounded[33], rounded}) >>> 16);
        if (y_wide[34]) begin
            y_sat = 16'h0000;
        end else if (|y_wide[33:16]) begin
            y_sat = 16'hFFFF;
        end else begin
            y_sat = y_wide[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= acc_en;
            overrun_q   <= audio_clk_en && busy;
            if (acc_en) begin
                y_q <= y_sat;
            end
        end
    end

    always_comb begin
        out       = y_q;
        out_valid = out_valid_q;
        overrun   = overrun_q;
    end

endmodule
